// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, bit-timer width and
// frame constants.
package uart_pkg;

  localparam int unsigned ACC_W     = 39;
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_BREAK
  } uart_state_e;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Fractional bit timer: signed accumulator steps by baud each clock and
// subtracts clkfreq on every tick, giving an average clkfreq/baud period.
module uart_baud_tick
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] baud,
  input  logic [31:0] clkfreq,
  output logic        tick
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] baud_x;
  logic [ACC_W-1:0] clkfreq_x;
  logic [ACC_W-1:0] step;

  assign baud_x    = {{(ACC_W-32){1'b0}}, baud};
  assign clkfreq_x = {{(ACC_W-32){1'b0}}, clkfreq};
  assign tick      = ~acc[ACC_W-1];

  always_comb begin
    step = baud_x;
    if (tick) step = baud_x - clkfreq_x;
  end

  always_ff @(posedge clk) begin
    if (reset)      acc <= '0;
    else if (load)  acc <= baud_x - clkfreq_x;
    else if (clear) acc <= '0;
    else            acc <= acc + step;
  end

endmodule

// File: rtl/uart_txq.sv
// Buffered UART transmitter: DEPTH-entry byte FIFO feeding an 8-bit serialiser
// with optional parity, one or two stop bits and a line-break condition.
module uart_txq
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              baud,
  input  logic [31:0]              clkfreq,
  input  logic                     wr,
  input  logic [7:0]               tx_data,
  input  logic                     parity_en,
  input  logic                     parity_odd,
  input  logic                     two_stop,
  input  logic                     send_break,
  output logic                     tx,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wptr;
  logic [AW-1:0]        rptr;
  logic [AW:0]          level_d;
  logic                 push;
  logic                 pop;

  uart_state_e          state_q, state_d;
  logic [BIT_IDX_W-1:0] bit_q, bit_d;
  logic [7:0]           shreg_q, shreg_d;
  logic                 par_en_q, par_en_d;
  logic                 par_q, par_d;
  logic                 two_stop_q, two_stop_d;
  logic                 tx_d;
  logic                 frame_end;
  logic                 tick;
  logic                 acc_load;
  logic                 acc_clear;

  assign push = wr & ~full;
  assign busy = (state_q != ST_IDLE) | (level != '0);

  always_comb begin
    level_d = level;
    if (push & ~pop)      level_d = level + {{AW{1'b0}}, 1'b1};
    else if (pop & ~push) level_d = level - {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      full  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      level <= level_d;
      full  <= (level_d == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wptr] <= tx_data;
  end

  uart_baud_tick u_tick (
    .clk     (clk),
    .reset   (reset),
    .clear   (acc_clear),
    .load    (acc_load),
    .baud    (baud),
    .clkfreq (clkfreq),
    .tick    (tick)
  );

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    par_en_d   = par_en_q;
    par_d      = par_q;
    two_stop_d = two_stop_q;
    pop        = 1'b0;
    acc_load   = 1'b0;
    frame_end  = 1'b0;
    tx_d       = 1'b1;

    unique case (state_q)
      ST_IDLE:  frame_end = 1'b1;
      ST_START: if (tick) begin
        state_d = ST_DATA;
        bit_d   = '0;
      end
      ST_DATA: if (tick) begin
        shreg_d = shreg_q >> 1;
        if (bit_q == BIT_IDX_W'(DATA_BITS-1)) state_d = par_en_q ? ST_PARITY : ST_STOP1;
        else                                  bit_d   = bit_q + 1'b1;
      end
      ST_PARITY: if (tick) state_d = ST_STOP1;
      ST_STOP1:  if (tick) begin
        if (two_stop_q) state_d = ST_STOP2;
        else            frame_end = 1'b1;
      end
      ST_STOP2: if (tick) frame_end = 1'b1;
      ST_BREAK: if (!send_break) begin
        // Reload so the closing mark lasts a full bit time.
        state_d    = ST_STOP1;
        two_stop_d = 1'b0;
        acc_load   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // A queued byte starts straight off the last stop tick; the accumulator is
    // only reloaded when leaving IDLE so back-to-back bits keep their phase.
    if (frame_end) begin
      if (send_break) begin
        state_d  = ST_BREAK;
        acc_load = 1'b1;
      end else if (level != '0) begin
        pop        = 1'b1;
        acc_load   = (state_q == ST_IDLE);
        shreg_d    = mem[rptr];
        par_en_d   = parity_en;
        par_d      = parity_bit(mem[rptr], parity_odd);
        two_stop_d = two_stop;
        state_d    = ST_START;
      end else begin
        state_d = ST_IDLE;
      end
    end

    acc_clear = (state_d == ST_IDLE);

    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
      ST_PARITY: tx_d = par_d;
      ST_BREAK:  tx_d = 1'b0;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      two_stop_q <= 1'b0;
      tx         <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_en_q   <= par_en_d;
      par_q      <= par_d;
      two_stop_q <= two_stop_d;
      tx         <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_txq.sv
// Self-checking bench for uart_txq: per-cycle waveform table, a serial
// receiver feeding a byte scoreboard, and hand-written corner sequences.
module tb_uart_txq;

  localparam int unsigned DEPTH = 16;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       po;
    logic       ts;
  } frame_t;

  typedef struct {
    frame_t      f;
    int unsigned cf;
    int unsigned bd;
    int unsigned len;
    logic        par;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] baud;
  logic [31:0] clkfreq;
  logic        wr;
  logic [7:0]  tx_data;
  logic        parity_en;
  logic        parity_odd;
  logic        two_stop;
  logic        send_break;
  logic        tx;
  logic        full;
  logic [4:0]  level;
  logic        busy;

  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic        mon_en = 1'b0;
  frame_t      exp_q[$];
  int unsigned starts[$];

  uart_txq #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .baud       (baud),
    .clkfreq    (clkfreq),
    .wr         (wr),
    .tx_data    (tx_data),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .send_break (send_break),
    .tx         (tx),
    .full       (full),
    .level      (level),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h required %0h", name, cyc, got, expv);
    end
  endtask

  function automatic logic frame_bit(input frame_t f, input int unsigned k);
    if (k == 0) return 1'b0;
    if (k <= 8) return f.d[k-1];
    if (k == 9 && f.pe) return (^f.d) ^ f.po;
    return 1'b1;
  endfunction

  function automatic int unsigned frame_len(input frame_t f);
    return 10 + int'(f.pe) + int'(f.ts);
  endfunction

  // Serial receiver: samples each bit near its centre and pops the scoreboard.
  task automatic monitor();
    frame_t      e;
    int unsigned cnt, tgt, nb;
    logic [31:0] got, expb;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        starts.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("rx_unexpected_frame", 32'd1, 32'd0);
          repeat (12 * (clkfreq / baud)) @(negedge clk);
        end else begin
          e = exp_q.pop_front();
          nb = frame_len(e);
          got = '0;
          expb = '0;
          cnt = 0;
          for (int unsigned k = 0; k < nb; k++) begin
            tgt = ((2 * k + 1) * clkfreq) / (2 * baud);
            while (cnt < tgt) begin
              @(negedge clk);
              cnt++;
            end
            got[k]  = tx;
            expb[k] = frame_bit(e, k);
          end
          check("rx_frame", got, expb);
        end
      end
    end
  endtask

  task automatic wait_idle(input int unsigned budget, input string name);
    int unsigned i = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, {31'd0, (exp_q.size() == 0 && busy === 1'b0)}, 32'd1);
  endtask

  initial begin
    vec_t        vt [7];
    vec_t        t;
    frame_t      fa, fb;
    int unsigned r, b, sum, s0, mlevel, runlen, ones;
    int unsigned runs[$];
    logic        expb, prev_tx, started;

    vt[0] = '{'{8'h55, 1'b0, 1'b0, 1'b0}, 16, 1, 10, 1'b0};
    vt[1] = '{'{8'hA3, 1'b1, 1'b0, 1'b1}, 16, 1, 12, 1'b0};
    vt[2] = '{'{8'hA3, 1'b1, 1'b1, 1'b0},  4, 1, 11, 1'b1};
    vt[3] = '{'{8'h00, 1'b1, 1'b0, 1'b0},  3, 1, 11, 1'b0};
    vt[4] = '{'{8'hFF, 1'b0, 1'b0, 1'b1},  2, 1, 11, 1'b0};
    vt[5] = '{'{8'h80, 1'b1, 1'b1, 1'b1}, 32, 2, 12, 1'b0};
    vt[6] = '{'{8'h7E, 1'b1, 1'b1, 1'b0}, 10, 5, 11, 1'b1};

    reset = 1'b1; wr = 1'b1; tx_data = 8'hEE;
    baud = 32'd1; clkfreq = 32'd16;
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0; send_break = 1'b0;
    fork monitor(); join_none

    // Reset state, with a push attempt held during reset.
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_level", level, 0);
    check("reset_full", full, 0);
    check("reset_busy", busy, 0);
    reset = 1'b0; wr = 1'b0;
    @(negedge clk);

    // Exact waveform per table vector, launched from an idle FIFO.
    for (int unsigned v = 0; v < 7; v++) begin
      t = vt[v];
      r = t.cf / t.bd;
      clkfreq = t.cf; baud = t.bd;
      parity_en = t.f.pe; parity_odd = t.f.po; two_stop = t.f.ts;
      mon_en = 1'b1;
      @(negedge clk);
      tx_data = t.f.d; wr = 1'b1;
      exp_q.push_back(t.f);
      @(negedge clk);
      wr = 1'b0;
      check("tbl_level_after_wr", level, 1);
      check("tbl_tx_before_start", tx, 1);
      check("tbl_busy_queued", busy, 1);
      for (int unsigned n = 0; n < t.len * r; n++) begin
        @(negedge clk);
        if (n == 0) begin
          check("tbl_level_after_pop", level, 0);
          parity_en = ~parity_en; parity_odd = ~parity_odd; two_stop = ~two_stop;
        end
        b = n / r;
        if (b == 0)                expb = 1'b0;
        else if (b <= 8)           expb = t.f.d[b-1];
        else if (b == 9 && t.f.pe) expb = t.par;
        else                       expb = 1'b1;
        check("tbl_tx", tx, expb);
        if (n == t.len * r - 1) check("tbl_busy_last_stop", busy, 1);
      end
      @(negedge clk);
      check("tbl_busy_after_frame", busy, 0);
      check("tbl_tx_after_frame", tx, 1);
    end

    // Fractional ratio 100/30: four back-to-back 0x55 frames toggle every bit.
    clkfreq = 32'd100; baud = 32'd30;
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    prev_tx = 1'b1; started = 1'b0; runlen = 0;
    for (int unsigned i = 0; i < 400 && runs.size() < 39; i++) begin
      if (i < 4) begin
        tx_data = 8'h55; wr = 1'b1;
        exp_q.push_back('{8'h55, 1'b0, 1'b0, 1'b0});
      end else begin
        wr = 1'b0;
      end
      @(negedge clk);
      if (!started) begin
        if (tx === 1'b0) begin started = 1'b1; runlen = 1; end
      end else if (tx !== prev_tx) begin
        runs.push_back(runlen);
        runlen = 1;
      end else begin
        runlen++;
      end
      prev_tx = tx;
    end
    wr = 1'b0;
    check("frac_bit_count", runs.size(), 39);
    foreach (runs[i]) check("frac_bit_len_3_or_4", {31'd0, (runs[i] == 3 || runs[i] == 4)}, 1);
    for (int unsigned w = 0; w + 30 <= runs.size(); w++) begin
      sum = 0;
      for (int unsigned j = 0; j < 30; j++) sum += runs[w + j];
      check("frac_30bit_window_100pm1", {31'd0, (sum >= 99 && sum <= 101)}, 1);
    end
    wait_idle(400, "frac_drain");

    // FIFO fill while the first frame runs: 17th push meets full and is dropped.
    clkfreq = 32'd16; baud = 32'd1;
    s0 = starts.size();
    @(negedge clk);
    tx_data = 8'h20; wr = 1'b1;
    exp_q.push_back('{8'h20, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    wr = 1'b0;
    repeat (5) @(negedge clk);
    mlevel = 0;
    for (int unsigned i = 0; i < 17; i++) begin
      tx_data = 8'h21 + 8'(i); wr = 1'b1;
      if (mlevel < DEPTH) begin
        exp_q.push_back('{8'h21 + 8'(i), 1'b0, 1'b0, 1'b0});
        mlevel++;
      end
      @(negedge clk);
      check("fill_level", level, mlevel);
      check("fill_full", full, {31'd0, (mlevel == DEPTH)});
    end
    wr = 1'b0;
    wait_idle(20 * 160 + 50, "fill_drain");
    check("fill_frame_count", starts.size() - s0, 17);
    for (int unsigned i = 1; i < 17 && s0 + i < starts.size(); i++)
      check("fill_back_to_back_period", starts[s0 + i] - starts[s0 + i - 1], 160);

    // Break requested mid-frame with 0x0F queued; R=4, released at n=60.
    mon_en = 1'b0;
    clkfreq = 32'd4; baud = 32'd1;
    fa = '{8'h3C, 1'b0, 1'b0, 1'b0};
    fb = '{8'h0F, 1'b0, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    for (int n = -2; n <= 110; n++) begin
      @(negedge clk);
      if (n >= 0) begin
        if (n < 40)       expb = frame_bit(fa, n / 4);
        else if (n <= 60) expb = 1'b0;
        else if (n <= 64) expb = 1'b1;
        else if (n < 105) expb = frame_bit(fb, (n - 65) / 4);
        else              expb = 1'b1;
        check("brk_tx", tx, expb);
      end
      if (n == 50) begin
        check("brk_level_held", level, 1);
        check("brk_busy", busy, 1);
      end
      if (n == 110) check("brk_busy_end", busy, 0);
      if (n == -2) begin tx_data = fa.d; wr = 1'b1; end
      if (n == -1) wr = 1'b0;
      if (n == 5)  begin tx_data = fb.d; wr = 1'b1; send_break = 1'b1; end
      if (n == 6)  wr = 1'b0;
      if (n == 60) send_break = 1'b0;
    end

    // Reset in mid-DATA with five bytes still queued.
    clkfreq = 32'd16; baud = 32'd1;
    @(negedge clk);
    for (int unsigned i = 0; i < 6; i++) begin
      tx_data = 8'hC0 + 8'(i); wr = 1'b1;
      @(negedge clk);
    end
    wr = 1'b0;
    repeat (30) @(negedge clk);
    check("rst_level_before", level, 5);
    check("rst_tx_in_data", tx, 1'b0);
    reset = 1'b1; wr = 1'b1; tx_data = 8'h99;
    @(negedge clk);
    check("rst_mid_tx", tx, 1);
    check("rst_mid_level", level, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_full", full, 0);
    reset = 1'b0; wr = 1'b0;
    ones = 0;
    for (int unsigned i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx === 1'b1 && busy === 1'b0) ones++;
    end
    check("rst_quiet_after", ones, 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
